// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control sequencer.
// Optional build macro: MULTICYCLE_CTRL_BNE_EN (adds bne to the legal opcode set).
// Holds the state enum, opcode constants, mux/ALU/trap encodings and the opcode decode.
package mips_ctrl_pkg;

  // IDLE must stay at 0 so state_dbg reads 0 while reset is asserted.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_ALU   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  // Successor of DECODE for a given opcode; unknown opcodes go to TRAP.
  function automatic state_t decode_opcode(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:     nxt = S_EXEC_R;
      OP_ADDI:      nxt = S_EXEC_I;
      OP_LW, OP_SW: nxt = S_MEM_ADDR;
      OP_BEQ:       nxt = S_BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
      OP_BNE:       nxt = S_BRANCH;
`endif
      OP_J:         nxt = S_JUMP;
      default:      nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Purpose: counts consecutive cycles spent waiting on a memory ready; flags the last allowed one.
// Latency: expired is combinational, high in the MEM_WAIT_MAX-th consecutive waiting cycle.
// Backpressure: none; clear (state change) has priority over counting.
module ctrl_wait_timer #(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_active,
  input  logic clear,
  output logic expired
);

  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT_MAX - 1);

  logic [CW-1:0] r_cnt;

  // The counter holds the number of waiting cycles already completed in this state.
  assign expired = wait_active && (r_cnt == LAST);

  // Count waiting cycles; restart whenever the sequencer changes state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (wait_active && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Purpose: multicycle MIPS control sequencer (Moore outputs, some gated by ready/zero_out); macro MULTICYCLE_CTRL_BNE_EN enables bne.
// Latency: R/addi 4, lw 5, sw 4, beq/j 3 cycles plus memory wait cycles; retire pulse in the last cycle.
// Backpressure: stalls in FETCH/MEM_RD/MEM_WR while ready is low; traps after MEM_WAIT_MAX waiting cycles.
module multicycle_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       instrn_opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             zero_out,
  output logic             pc_write_en,
  output logic [1:0]       pc_src,
  output logic             ir_write_en,
  output logic             reg_dst,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             ctrl_write_en,
  output logic             mem_to_reg,
  output logic             datamem_read_en,
  output logic             ctrl_datamem_write_en,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [3:0]       state_dbg
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_is_rtype;
  logic             r_is_store;
  logic [1:0]       r_trap_cause;
  logic [CNT_W-1:0] r_retire_cnt;
  logic             w_wait_active;
  logic             w_wait_clear;
  logic             w_wait_expired;
  logic             w_branch_taken;

`ifdef MULTICYCLE_CTRL_BNE_EN
  logic r_is_bne;
  assign w_branch_taken = r_is_bne ? ~zero_out : zero_out;
`else
  assign w_branch_taken = zero_out;
`endif

  assign w_wait_active = ((r_state == S_FETCH)  && !imem_ready) ||
                         ((r_state == S_MEM_RD) && !dmem_ready) ||
                         ((r_state == S_MEM_WR) && !dmem_ready);
  assign w_wait_clear  = (w_state_nxt != r_state);

  ctrl_wait_timer #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX)
  ) u_wait_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .wait_active (w_wait_active),
    .clear       (w_wait_clear),
    .expired     (w_wait_expired)
  );

  // State register; reset aborts any instruction straight to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: ready wins over the timeout in the same cycle; TRAP is terminal.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ready)          w_state_nxt = S_DECODE;
        else if (w_wait_expired) w_state_nxt = S_TRAP;
      end
      S_DECODE:   w_state_nxt = decode_opcode(instrn_opcode);
      S_EXEC_R,
      S_EXEC_I:   w_state_nxt = S_WB_ALU;
      S_MEM_ADDR: w_state_nxt = r_is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (dmem_ready)          w_state_nxt = S_WB_MEM;
        else if (w_wait_expired) w_state_nxt = S_TRAP;
      end
      S_MEM_WR: begin
        if (dmem_ready)          w_state_nxt = S_FETCH;
        else if (w_wait_expired) w_state_nxt = S_TRAP;
      end
      S_WB_ALU,
      S_WB_MEM,
      S_BRANCH,
      S_JUMP:     w_state_nxt = S_FETCH;
      S_TRAP:     w_state_nxt = S_TRAP;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the current state; only FETCH, MEM_WR and BRANCH look at inputs.
  always_comb begin
    pc_write_en           = 1'b0;
    pc_src                = PC_SRC_PLUS4;
    ir_write_en           = 1'b0;
    reg_dst               = 1'b0;
    alu_src_b             = 1'b0;
    alu_op                = ALU_OP_ADD;
    ctrl_write_en         = 1'b0;
    mem_to_reg            = 1'b0;
    datamem_read_en       = 1'b0;
    ctrl_datamem_write_en = 1'b0;
    instr_retired         = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_write_en = imem_ready;
        pc_write_en = imem_ready;
      end
      S_EXEC_R: begin
        alu_op  = ALU_OP_FUNC;
        reg_dst = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_b = 1'b1;
      end
      S_WB_ALU: begin
        // Destination and ALU controls stay as they were in the EXEC state.
        ctrl_write_en = 1'b1;
        reg_dst       = r_is_rtype;
        alu_op        = r_is_rtype ? ALU_OP_FUNC : ALU_OP_ADD;
        alu_src_b     = ~r_is_rtype;
        instr_retired = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_b = 1'b1;
      end
      S_MEM_RD: begin
        datamem_read_en = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_datamem_write_en = 1'b1;
        instr_retired         = dmem_ready;
      end
      S_WB_MEM: begin
        ctrl_write_en = 1'b1;
        mem_to_reg    = 1'b1;
        instr_retired = 1'b1;
      end
      S_BRANCH: begin
        alu_op        = ALU_OP_SUB;
        pc_src        = PC_SRC_BRANCH;
        pc_write_en   = w_branch_taken;
        instr_retired = 1'b1;
      end
      S_JUMP: begin
        pc_src        = PC_SRC_JUMP;
        pc_write_en   = 1'b1;
        instr_retired = 1'b1;
      end
      default: ;
    endcase
  end

  // Instruction class is captured at DECODE so later states never re-sample the opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_rtype <= 1'b0;
      r_is_store <= 1'b0;
`ifdef MULTICYCLE_CTRL_BNE_EN
      r_is_bne   <= 1'b0;
`endif
    end else if (r_state == S_DECODE) begin
      r_is_rtype <= (instrn_opcode == OP_RTYPE);
      r_is_store <= (instrn_opcode == OP_SW);
`ifdef MULTICYCLE_CTRL_BNE_EN
      r_is_bne   <= (instrn_opcode == OP_BNE);
`endif
    end
  end

  // Trap cause is latched on entry: from DECODE it is an illegal opcode, otherwise a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap_cause <= TRAP_NONE;
    end else if ((w_state_nxt == S_TRAP) && (r_state != S_TRAP)) begin
      r_trap_cause <= (r_state == S_DECODE) ? TRAP_ILLEGAL : TRAP_TIMEOUT;
    end
  end

  // Retired-instruction counter advances on the edge closing the retire cycle and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_retire_cnt <= '0;
    else if (instr_retired) r_retire_cnt <= r_retire_cnt + 1'b1;
  end

  assign retire_cnt = r_retire_cnt;
  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_trap_cause;
  assign state_dbg  = r_state;

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the MIPS datapath. It replaces the single-cycle control decode so fetch, register read, ALU, data memory and writeback use separate clock cycles.
- Drives PC and IR load enables, datapath mux selects, ALU op class, and register-file and data-memory enables.
- Waits on ready handshakes from instruction and data memory.
- Traps on illegal opcodes and on memory timeouts, and counts retired instructions.

Parameters:
- MEM_WAIT_MAX, 16, maximum consecutive cycles the FSM waits on a ready signal before trapping (≥1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- instrn_opcode  input  6  IR[31:26]
- imem_ready  input  1  instruction word valid this cycle
- dmem_ready  input  1  data-memory access complete this cycle
- zero_out  input  1  ALU zero flag
- pc_write_en  output  1  load PC this cycle
- pc_src  output  2  00 = PC+4, 01 = branch_address, 10 = jump target
- ir_write_en  output  1  latch instruction register
- reg_dst  output  1  0 = rt, 1 = rd
- alu_src_b  output  1  0 = read_data2, 1 = sign_ext_out
- alu_op  output  2  00 = add, 01 = sub, 10 = use func_field
- ctrl_write_en  output  1  register-file write enable
- mem_to_reg  output  1  0 = ALU result, 1 = datamem_read_data
- datamem_read_en  output  1  data-memory read strobe
- ctrl_datamem_write_en  output  1  data-memory write strobe
- instr_retired  output  1  one-cycle pulse when an instruction completes
- retire_cnt  output  CNT_W  retired-instruction count, wraps
- trap  output  1  sticky halt indication
- trap_cause  output  2  01 = illegal opcode, 10 = memory timeout
- state_dbg  output  4  current state encoding

Behaviour:
- Reset: one clock, asynchronous active-low reset (rst_n).
  - On reset, state = IDLE.
  - All outputs are 0, including retire_cnt, trap and trap_cause.
  - IDLE advances to FETCH on the first clock after rst_n deasserts.
- Outputs are decoded from the current state (Moore), except where noted as gated by ready or zero_out.
- FETCH
  - While imem_ready = 0: stay in FETCH, all enables 0.
  - When imem_ready = 1: ir_write_en = 1, pc_write_en = 1, pc_src = 00, then go to DECODE.
- DECODE (register read), transition by opcode:
  - 0x00 → EXEC_R
  - 0x08 (addi) → EXEC_I
  - 0x23 (lw) or 0x2B (sw) → MEM_ADDR
  - 0x04 (beq) → BRANCH
  - 0x02 (j) → JUMP
  - anything else → TRAP with cause 01
- EXEC_R: alu_op = 10, alu_src_b = 0, reg_dst = 1, then WB_ALU.
- EXEC_I: alu_op = 00, alu_src_b = 1, reg_dst = 0, then WB_ALU.
- WB_ALU: ctrl_write_en = 1 and mem_to_reg = 0; reg_dst and alu ctrl held from the previous state; retire; then FETCH.
- MEM_ADDR: alu_op = 00, alu_src_b = 1. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: datamem_read_en = 1, held until dmem_ready = 1, then WB_MEM.
- MEM_WR: ctrl_datamem_write_en = 1, held until dmem_ready = 1. Retire on the ready cycle, then FETCH.
- WB_MEM: ctrl_write_en = 1, mem_to_reg = 1, reg_dst = 0; retire; then FETCH.
- BRANCH: alu_op = 01, alu_src_b = 0, pc_src = 01, pc_write_en = zero_out; retire; then FETCH.
- JUMP: pc_src = 10, pc_write_en = 1; retire; then FETCH.
- Latencies excluding wait cycles:
  - R/addi: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/j: 3 cycles
- Wait counter:
  - Increments each cycle in FETCH, MEM_RD or MEM_WR while the relevant ready = 0.
  - Clears on any state change.
  - Reaching MEM_WAIT_MAX with ready still 0 → TRAP with cause 10. A ready arriving in that same cycle wins (no trap).
- TRAP: all enables 0, trap = 1, no exit except reset. The opcode is not re-sampled.
- instr_retired: pulses exactly one cycle per instruction. retire_cnt increments on the same clock edge and wraps from all-ones to 0.
- Mid-operation reset: the FSM aborts immediately to IDLE and all strobes drop asynchronously.

Optional Feature:
- Macro: MULTICYCLE_CTRL_BNE_EN.
- Defined: opcode 0x05 (bne) → BRANCH with pc_write_en = ~zero_out.
- Undefined: 0x05 is illegal (TRAP, cause 01).

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J)
  - pc_src, alu_op and trap_cause encodings
- One sub-module, ctrl_wait_timer: the MEM_WAIT_MAX wait counter, with inputs wait_active/clear and output expired.

Test Plan:
- rst_n low mid-MEM_RD → all outputs 0 within the same cycle. IDLE on release, FETCH one clock later.
- R-type (opcode 0x00), ready always 1 → states FETCH, DECODE, EXEC_R, WB_ALU. ctrl_write_en = 1 with reg_dst = 1 only in cycle 4. retire_cnt goes 0→1.
- lw with dmem_ready low for 3 cycles → MEM_RD is held 4 cycles. WB_MEM asserts mem_to_reg = 1. Total 8 cycles.
- beq with zero_out = 1, then with zero_out = 0 → pc_write_en = 1 / pc_src = 01 in the first case, pc_write_en = 0 in the second. Each takes 3 cycles.
- Opcode 0x3F → TRAP after DECODE, trap_cause = 01, held for 100 cycles until reset. With the macro defined, 0x05 plus zero_out = 0 → branch taken.
- imem_ready stuck at 0 with MEM_WAIT_MAX = 16 → TRAP after 16 FETCH cycles, cause 10. Ready asserted on cycle 16 → no trap.
